imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Decode-stage RISC-V immediate generator with XLEN-parametrised sign extension, an explicit format
//  tag and a DEPTH-entry output queue with valid/ready handshakes on both sides. Sits between fetch
//  and the register-read/ALU-operand mux. Absorbs execute-stage stalls and drops wrong-path
//  instructions on flush.
// PARAMETERS
//  XLEN   64  datapath width; legal values 32 or 64
//  DEPTH  2   output queue entries; >=1
// PORTS
//  clk        in   1     sole clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     synchronous queue clear (branch mispredict / trap)
//  in_valid   in   1     inst is presented
//  in_ready   out  1     block accepts inst this cycle
//  inst       in   32    raw instruction word
//  out_valid  out  1     queue head holds a result
//  out_ready  in   1     consumer takes head this cycle
//  imm        out  XLEN  expanded immediate (head entry)
//  fmt        out  3     0 NONE,1 I,2 S,3 B,4 U,5 J,6 SH(shamt),7 Z(CSR)
//  occupancy  out  clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  Reset: out_valid=0, imm=0, fmt=0, occupancy=0; in_ready=0 while rst=1, 1 on first cycle after.
//  Handshake: push when in_valid&&in_ready; pop when out_valid&&out_ready. in_valid/inst held until accepted.
//  in_ready = !rst && (occupancy<DEPTH); no pass-through when full (no push+pop at full).
//  Latency: inst accepted at edge N into empty queue -> out_valid=1 with its imm/fmt after edge N.
//  Push+pop same edge at 0<occupancy<DEPTH: occupancy unchanged, order preserved (circular buffer, ptr wrap at DEPTH-1->0).
//  imm/fmt are registered from the head entry; out_valid=0 -> imm=0, fmt=0.
//  flush: next cycle occupancy=0, out_valid=0, ptrs=0; same-cycle in_valid ignored (not accepted),
//   same-cycle pop ignored. rst has priority over flush.
//  Decode (sext = sign-extend from inst[31] to XLEN):
//   0000011 load, 1100111 JALR, 0010011 ALU-imm (funct3 not 001/101): I, sext(inst[31:20])
//   0010011 funct3 001/101: SH, zero-ext shamt = inst[25:20] (XLEN=64) / inst[24:20] (XLEN=32)
//   0011011 (XLEN=64 only): funct3 001/101 SH inst[24:20] zero-ext; else I sext; XLEN=32 -> NONE
//   0100011: S, sext({inst[31:25],inst[11:7]})
//   1100011: B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   0110111/0010111: U, sext({inst[31:12],12'h000})
//   1101111: J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   all other opcodes (incl. R-type): NONE, imm=0
// CONFIGURATION
//  IMM_GEN_CSR_EN defined: opcode 1110011 funct3 101/110/111 -> Z, imm=zero-ext inst[19:15];
//   funct3 001/010/011 -> Z, imm=zero-ext inst[31:20] (CSR address); funct3 000/100 -> NONE.
//  Not defined: opcode 1110011 -> NONE, imm=0; fmt code 7 never produced.
// TESTING (XLEN=64, DEPTH=2 unless noted)
//  0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, fmt=1
//  0xFE000EE3 (beq -4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=3; 0x43F0D093 (srai x1,x1,63) -> imm=0x3F, fmt=6
//  0x123452B7 -> imm=0x0000000012345000; 0x800002B7 -> imm=0xFFFFFFFF80000000, fmt=4 (XLEN=32: 0x80000000)
//  out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0, occupancy=2, C held; out_ready=1 -> A,B,C out in order
//  queue full + in_valid=1 + flush=1 -> next cycle occupancy=0, out_valid=0, input not accepted
//  0x3002D0F3 (csrrwi x1,0x300,5): with IMM_GEN_CSR_EN imm=5, fmt=7; without imm=0, fmt=0

Source files
------------

// File: rtl/imm_gen_if.sv
// ---------------------------------------------------------------------------
// imm_gen_if
//   Handshake bundle around the immediate generator: an instruction input
//   channel (valid/ready + 32-bit word) and a result output channel
//   (valid/ready + expanded immediate, format tag, queue occupancy).
//
//   Modports
//     master : fetch side / consumer side (drives in_valid, inst, out_ready)
//     slave  : the immediate generator   (drives in_ready, out_valid, imm,
//                                          fmt, occupancy)
// ---------------------------------------------------------------------------
interface imm_gen_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) ();

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       fmt;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, imm, fmt, occupancy
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, imm, fmt, occupancy
  );

endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Decode-stage RISC-V immediate generator. Each accepted instruction is
//   decoded into an XLEN-wide immediate plus a 3-bit format tag and parked
//   in a DEPTH-entry circular queue, so execute-stage stalls are absorbed
//   without back-pressuring the decoder combinationally. A flush drops all
//   queued (wrong-path) entries.
//
//   Parameters
//     XLEN  : datapath width, 32 or 64
//     DEPTH : queue entries, >= 1
//
//   Ports
//     clk   : clock, all state on rising edge
//     rst   : synchronous active-high reset
//     flush : synchronous queue clear; same-cycle push and pop are dropped
//     bus   : imm_gen_if.slave
//               in_valid/in_ready/inst      instruction input channel
//               out_valid/out_ready         result output channel
//               imm/fmt                     head entry (zero when empty)
//               occupancy                   entries held
//
//   Format tags: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH (shamt), 7 Z (CSR)
//
//   Build option
//     IMM_GEN_CSR_EN : when defined, SYSTEM-opcode CSR instructions produce
//                      tag Z (uimm or CSR address); otherwise they decode as
//                      NONE and tag 7 is never produced.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  imm_gen_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd7;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } entry_t;

  // Immediate expansion. Each signed-format field is first assembled at its
  // natural width as a signed value, then widened with a size cast so the
  // sign extension is carried by the type rather than by replication (this
  // keeps XLEN=32 legal where a 32-bit field needs no extension at all).
  function automatic entry_t decode(input logic [31:0] ins);
    entry_t             e;
    logic [6:0]         op;
    logic [2:0]         f3;
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [31:0] u_imm;
    logic signed [20:0] j_imm;
    logic               is_shift;

    op       = ins[6:0];
    f3       = ins[14:12];
    i_imm    = ins[31:20];
    s_imm    = {ins[31:25], ins[11:7]};
    b_imm    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm    = {ins[31:12], 12'h000};
    j_imm    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    e.fmt = FMT_NONE;
    e.imm = '0;

    case (op)
      OP_LOAD, OP_JALR: begin
        e.fmt = FMT_I;
        e.imm = XLEN'(i_imm);
      end
      OP_IMM: begin
        if (is_shift) begin
          // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one; always unsigned.
          e.fmt = FMT_SH;
          if (XLEN == 64) e.imm = XLEN'(ins[25:20]);
          else            e.imm = XLEN'(ins[24:20]);
        end else begin
          e.fmt = FMT_I;
          e.imm = XLEN'(i_imm);
        end
      end
      OP_IMM32: begin
        // Word-sized ops only exist in RV64.
        if (XLEN == 64) begin
          if (is_shift) begin
            e.fmt = FMT_SH;
            e.imm = XLEN'(ins[24:20]);
          end else begin
            e.fmt = FMT_I;
            e.imm = XLEN'(i_imm);
          end
        end
      end
      OP_STORE: begin
        e.fmt = FMT_S;
        e.imm = XLEN'(s_imm);
      end
      OP_BRANCH: begin
        e.fmt = FMT_B;
        e.imm = XLEN'(b_imm);
      end
      OP_LUI, OP_AUIPC: begin
        e.fmt = FMT_U;
        e.imm = XLEN'(u_imm);
      end
      OP_JAL: begin
        e.fmt = FMT_J;
        e.imm = XLEN'(j_imm);
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        // funct3 1xx carries a 5-bit uimm in the rs1 field; 0xx carries
        // only the CSR address. 000/100 are ECALL/EBREAK/xRET/etc.
        case (f3)
          3'b101, 3'b110, 3'b111: begin
            e.fmt = FMT_Z;
            e.imm = XLEN'(ins[19:15]);
          end
          3'b001, 3'b010, 3'b011: begin
            e.fmt = FMT_Z;
            e.imm = XLEN'(ins[31:20]);
          end
          default: begin
            e.fmt = FMT_NONE;
            e.imm = '0;
          end
        endcase
`else
        e.fmt = FMT_NONE;
        e.imm = '0;
`endif
      end
      default: begin
        e.fmt = FMT_NONE;
        e.imm = '0;
      end
    endcase
    return e;
  endfunction

  // Circular pointer advance; wraps DEPTH-1 -> 0 even when DEPTH is not a
  // power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  entry_t           mem_p1 [DEPTH];
  entry_t           entry_p0;
  logic             vld_p0;
  logic             vld_p1;
  logic             push;
  logic             pop;

  // ---- stage p0: handshake qualification and combinational decode --------
  assign bus.in_ready = !rst && (occ < OCC_W'(DEPTH));
  assign vld_p0       = bus.in_valid && bus.in_ready;
  assign entry_p0     = decode(bus.inst);

  // Flush squashes both sides of the handshake in the same cycle.
  assign push = vld_p0 && !flush;
  assign pop  = vld_p1 && bus.out_ready && !flush;

  // ---- stage p1: queue storage and control -------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= entry_p0;
  end

  assign vld_p1 = (occ != '0);

  // Head entry is gated to zero when empty so stale payload never leaks.
  assign bus.out_valid = vld_p1;
  assign bus.imm       = vld_p1 ? mem_p1[rd_ptr].imm : '0;
  assign bus.fmt       = vld_p1 ? mem_p1[rd_ptr].fmt : FMT_NONE;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Self-checking bench for imm_gen_pipe (XLEN=64, DEPTH=2): reset state,
//   directed immediate vectors, back-to-back fill/drain ordering, flush while
//   full, and a randomized run against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  imm_gen_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: immediates rebuilt numerically from the RISC-V field
  // definitions using signed 64-bit arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t        r;
    longint      top;
    logic [6:0]  op;
    logic [2:0]  f3;
    op    = i[6:0];
    f3    = i[14:12];
    top   = longint'($signed(i));
    r.fmt = 3'd0;
    r.imm = 64'd0;
    case (op)
      7'h03, 7'h67: begin r.fmt = 3'd1; r.imm = top >>> 20; end
      7'h13, 7'h1B: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          r.fmt = 3'd6;
          r.imm = (op == 7'h13) ? 64'(i[25:20]) : 64'(i[24:20]);
        end else begin
          r.fmt = 3'd1;
          r.imm = top >>> 20;
        end
      end
      7'h23: begin r.fmt = 3'd2; r.imm = (top >>> 25) * 32 + longint'(i[11:7]); end
      7'h63: begin
        r.fmt = 3'd3;
        r.imm = (top >>> 31) * 4096 + longint'(i[7]) * 2048
              + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'h37, 7'h17: begin r.fmt = 3'd4; r.imm = (top >>> 12) * 4096; end
      7'h6F: begin
        r.fmt = 3'd5;
        r.imm = (top >>> 31) * 1048576 + longint'(i[19:12]) * 4096
              + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
`ifdef IMM_GEN_CSR_EN
      7'h73: begin
        if (f3 >= 3'd5)                  begin r.fmt = 3'd7; r.imm = 64'(i[19:15]); end
        else if (f3 >= 3'd1 && f3 <= 3'd3) begin r.fmt = 3'd7; r.imm = 64'(i[31:20]); end
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
    w = $urandom();
    return {w[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.inst = 32'd0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.imm !== 64'd0) begin errors++; $display("FAIL reset_imm got %h want 0", bus.imm); end
    checks++; if (bus.fmt !== 3'd0) begin errors++; $display("FAIL reset_fmt got %0d want 0", bus.fmt); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_vectors();
    logic [31:0] vi [6];
    logic [63:0] vimm [6];
    logic [2:0]  vfmt [6];
    vi   = '{32'hFFF00093, 32'hFE000EE3, 32'h43F0D093, 32'h123452B7, 32'h800002B7, 32'h3002D0F3};
    vimm = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h3F,
             64'h0000000012345000, 64'hFFFFFFFF80000000,
`ifdef IMM_GEN_CSR_EN
             64'h5};
`else
             64'h0};
`endif
    vfmt = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd4,
`ifdef IMM_GEN_CSR_EN
             3'd7};
`else
             3'd0};
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1; bus.inst = vi[k];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid got %0b want 1", k, bus.out_valid); end
      checks++; if (bus.imm !== vimm[k]) begin errors++; $display("FAIL vec%0d_imm got %h want %h", k, bus.imm, vimm[k]); end
      checks++; if (bus.fmt !== vfmt[k]) begin errors++; $display("FAIL vec%0d_fmt got %0d want %0d", k, bus.fmt, vfmt[k]); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_drain got %0b want 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    exp_t        e;
    int          got;
    int          budget;
    for (int k = 0; k < 3; k++) w[k] = gen_inst();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.inst = w[k];
      @(posedge clk); #1;
    end
    checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL b2b_occ got %0d want 2", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %0b want 0", bus.in_ready); end
    e = ref_decode(w[0]);
    checks++; if (bus.imm !== e.imm) begin errors++; $display("FAIL b2b_head_imm got %h want %h", bus.imm, e.imm); end
    // C stays presented; drain with out_ready=1 and expect A, B, C in order.
    bus.out_ready = 1'b1;
    got = 0; budget = 0;
    while (got < 3 && budget < 20) begin
      if (bus.out_valid === 1'b1) begin
        e = ref_decode(w[got]);
        checks++; if (bus.imm !== e.imm || bus.fmt !== e.fmt) begin
          errors++; $display("FAIL b2b_order%0d got %h/%0d want %h/%0d", got, bus.imm, bus.fmt, e.imm, e.fmt);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        @(posedge clk); #1; bus.in_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      budget++;
    end
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_drain_timeout got %0d want 3", got); end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_flush_full();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.inst = gen_inst();
      @(posedge clk); #1;
    end
    checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill got %0d want 2", bus.occupancy); end
    bus.inst = 32'hFFF00093; bus.out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", bus.occupancy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.imm !== 64'd0) begin errors++; $display("FAIL flush_imm got %h want 0", bus.imm); end
    @(posedge clk); #1;
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_noaccept got %0d want 0", bus.occupancy); end
  endtask

  // Flush also held in the non-full case: a push in the flush cycle is dropped.
  task automatic test_flush_partial();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.inst = 32'h123452B7;
    @(posedge clk); #1;
    flush = 1'b1; bus.inst = 32'hFE000EE3;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_partial_occ got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_random();
    exp_t        q [$];
    exp_t        h;
    logic        pend;
    logic [31:0] pinst;
    logic        cap;
    logic        acc;
    logic        deq;
    pend = 1'b0; pinst = 32'd0;
    for (int c = 0; c < 600; c++) begin
      // outputs vs model
      checks++; if (bus.occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", c, bus.occupancy, q.size()); end
      checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, bus.out_valid, q.size() != 0); end
      checks++; if (bus.in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", c, bus.in_ready, q.size() < DEPTH); end
      if (q.size() != 0) h = q[0]; else begin h.imm = 64'd0; h.fmt = 3'd0; end
      checks++; if (bus.imm !== h.imm || bus.fmt !== h.fmt) begin
        errors++; $display("FAIL rnd_head cyc %0d got %h/%0d want %h/%0d", c, bus.imm, bus.fmt, h.imm, h.fmt);
      end
      // stimulus (an un-accepted instruction stays presented)
      if (!pend && ($urandom_range(0, 3) != 0)) begin pend = 1'b1; pinst = gen_inst(); end
      bus.in_valid  = pend;
      bus.inst      = pinst;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      cap = (q.size() < DEPTH);
      acc = pend && cap && !flush;
      deq = (q.size() != 0) && bus.out_ready && !flush;
      @(posedge clk); #1;
      if (flush) begin
        q.delete();
        pend = 1'b0;
      end else begin
        if (deq) void'(q.pop_front());
        if (acc) begin q.push_back(ref_decode(pinst)); pend = 1'b0; end
      end
    end
    flush = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush_full();
    test_flush_partial();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
